// File: rtl/npu_mem_pkg.sv
// Shared constants for the NPU memory subsystem: client ids, bank ids and
// index-width helpers used by the SRAM bank arbiter.
package npu_mem_pkg;

  // Requester indices. These set the bit positions of every per-client bus.
  localparam int CLI_AXI4  = 0;
  localparam int CLI_GEMM  = 1;
  localparam int CLI_ELEM  = 2;
  localparam int CLI_QUANT = 3;

  localparam int NUM_CLIENTS_DEF = 4;
  localparam int NUM_SRAMS_DEF   = 4;

  // Width of an index into n items. Never returns 0, so a single bank or a
  // single client still gets a 1-bit field.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BANK_W = idx_width(NUM_SRAMS_DEF);
  localparam int CLI_W  = idx_width(NUM_CLIENTS_DEF);

  // Default bank assignment of the engine working buffers.
  localparam int GEMM0_SRAM_IDX = 0;
  localparam int GEMM1_SRAM_IDX = 1;
  localparam int ELEM0_SRAM_IDX = 2;

endpackage

// File: rtl/rr_bank_sel.sv
// Grant selector for a single SRAM bank: candidate mask, lock override,
// strict-priority override and round-robin. Holds this bank's rr pointer and
// its lock/owner state, and produces a one-hot grant plus the winner index.
module rr_bank_sel
  import npu_mem_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int BANK_W      = 2,
  parameter int CLI_W       = 2,
  parameter int BANK_IDX    = 0,
  parameter bit PRIO_EN     = 1'b1,
  parameter int PRIO_CLIENT = 0
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [NUM_CLIENTS-1:0]        req_valid,
  input  logic [NUM_CLIENTS-1:0]        req_lock,
  input  logic [NUM_CLIENTS*BANK_W-1:0] req_bank,
  output logic [NUM_CLIENTS-1:0]        grant,
  output logic                          grant_any,
  output logic [CLI_W-1:0]              grant_idx,
  output logic                          busy
);

  logic [NUM_CLIENTS-1:0] cand;
  logic                   win_found;
  logic [CLI_W-1:0]       win_idx;

  logic [CLI_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [CLI_W-1:0] owner_q, owner_d;

  // Clients with a valid request aimed at this bank.
  always_comb begin
    cand = '0;
    for (int c = 0; c < NUM_CLIENTS; c++) begin
      cand[c] = req_valid[c] && (req_bank[c*BANK_W +: BANK_W] == BANK_W'(BANK_IDX));
    end
  end

  // Winner: lock owner only when locked, else priority client, else first
  // candidate at or after the rr pointer. Nothing is granted during reset.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    if (lock_q) begin
      if (cand[owner_q]) begin
        win_found = 1'b1;
        win_idx   = owner_q;
      end
    end else if (PRIO_EN && cand[PRIO_CLIENT]) begin
      win_found = 1'b1;
      win_idx   = CLI_W'(PRIO_CLIENT);
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (!win_found && cand[(int'(rr_ptr_q) + i) % NUM_CLIENTS]) begin
          win_found = 1'b1;
          win_idx   = CLI_W'((int'(rr_ptr_q) + i) % NUM_CLIENTS);
        end
      end
    end
    if (!arst) begin
      win_found = 1'b0;
    end
  end

  // One-hot grant vector derived from the winner index.
  always_comb begin
    grant = '0;
    for (int c = 0; c < NUM_CLIENTS; c++) begin
      grant[c] = win_found && (win_idx == CLI_W'(c));
    end
  end

  assign grant_any = win_found;
  assign grant_idx = win_idx;
  assign busy      = lock_q;

  // Pointer and lock bookkeeping. Every grant, including priority and locked
  // grants, moves the pointer past the winner. A locked bank can only grant
  // its owner, so an unlocked grant on a locked bank is the owner releasing.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    lock_d   = lock_q;
    owner_d  = owner_q;
    if (win_found) begin
      rr_ptr_d = (int'(win_idx) == NUM_CLIENTS - 1) ? '0 : win_idx + CLI_W'(1);
      if (req_lock[win_idx]) begin
        lock_d  = 1'b1;
        owner_d = win_idx;
      end else if (lock_q) begin
        lock_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arst) begin
      rr_ptr_q <= '0;
      lock_q   <= 1'b0;
      owner_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      owner_q  <= owner_d;
    end
  end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Multi-client, multi-bank SRAM arbiter. One rr_bank_sel per bank picks a
// winner, the winner drives that bank's SRAM port in the same cycle, and a
// per-bank {valid, client} tag pipeline routes read data back to the client.
//
// Handshake: a request transfers in a cycle where req_valid[c] && req_ready[c].
// req_ready is combinational from the current requests and may toggle freely;
// a client that is not granted must hold its request stable until it is.
// rsp_valid[c] is a one-cycle pulse with no backpressure.
module sram_bank_arbiter
  import npu_mem_pkg::*;
#(
  parameter  int NUM_CLIENTS     = 4,
  parameter  int NUM_SRAMS       = 4,
  parameter  int MAX_ADDR_WIDTH  = 12,
  parameter  int MAX_DATA_WIDTH  = 64,
  parameter  int SRAM_RD_LATENCY = 1,
  parameter  bit PRIO_EN         = 1'b1,
  parameter  int PRIO_CLIENT     = CLI_AXI4,
  localparam int BW              = idx_width(NUM_SRAMS),
  localparam int CW              = idx_width(NUM_CLIENTS),
  localparam int AW              = MAX_ADDR_WIDTH,
  localparam int DW              = MAX_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [NUM_CLIENTS-1:0]    req_valid,
  output logic [NUM_CLIENTS-1:0]    req_ready,
  input  logic [NUM_CLIENTS-1:0]    req_we,
  input  logic [NUM_CLIENTS-1:0]    req_lock,
  input  logic [NUM_CLIENTS*BW-1:0] req_bank,
  input  logic [NUM_CLIENTS*AW-1:0] req_addr,
  input  logic [NUM_CLIENTS*DW-1:0] req_wdata,
  output logic [NUM_CLIENTS-1:0]    rsp_valid,
  output logic [NUM_CLIENTS*DW-1:0] rsp_rdata,
  output logic [NUM_SRAMS-1:0]      sram_en,
  output logic [NUM_SRAMS-1:0]      sram_we,
  output logic [NUM_SRAMS*AW-1:0]   sram_addr,
  output logic [NUM_SRAMS*DW-1:0]   sram_wdata,
  input  logic [NUM_SRAMS*DW-1:0]   sram_rdata,
  output logic [NUM_SRAMS-1:0]      bank_busy
);

  localparam int LAT = SRAM_RD_LATENCY;

  logic [NUM_CLIENTS-1:0] bank_grant [NUM_SRAMS];
  logic [CW-1:0]          bank_win   [NUM_SRAMS];
  logic [NUM_SRAMS-1:0]   bank_any;

  // Read-tag pipeline, stage LAT-1 lines up with the SRAM read data.
  logic          pipe_vld_q [NUM_SRAMS][LAT];
  logic          pipe_vld_d [NUM_SRAMS][LAT];
  logic [CW-1:0] pipe_cid_q [NUM_SRAMS][LAT];
  logic [CW-1:0] pipe_cid_d [NUM_SRAMS][LAT];

  logic [NUM_CLIENTS*DW-1:0] rsp_rdata_q, rsp_rdata_d;

  for (genvar b = 0; b < NUM_SRAMS; b++) begin : g_bank
    rr_bank_sel #(
      .NUM_CLIENTS (NUM_CLIENTS),
      .BANK_W      (BW),
      .CLI_W       (CW),
      .BANK_IDX    (b),
      .PRIO_EN     (PRIO_EN),
      .PRIO_CLIENT (PRIO_CLIENT)
    ) u_sel (
      .clk       (clk),
      .arst      (arst),
      .req_valid (req_valid),
      .req_lock  (req_lock),
      .req_bank  (req_bank),
      .grant     (bank_grant[b]),
      .grant_any (bank_any[b]),
      .grant_idx (bank_win[b]),
      .busy      (bank_busy[b])
    );
  end

  // A client targets one bank per cycle, so OR-ing the bank grants is safe.
  always_comb begin
    req_ready = '0;
    for (int b = 0; b < NUM_SRAMS; b++) begin
      req_ready = req_ready | bank_grant[b];
    end
  end

  // Drive each granted bank from its winner; idle banks drive all zeros.
  always_comb begin
    sram_en    = '0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    for (int b = 0; b < NUM_SRAMS; b++) begin
      if (bank_any[b]) begin
        sram_en[b]                 = 1'b1;
        sram_we[b]                 = req_we[bank_win[b]];
        sram_addr[b*AW +: AW]      = req_addr[int'(bank_win[b])*AW +: AW];
        sram_wdata[b*DW +: DW]     = req_wdata[int'(bank_win[b])*DW +: DW];
      end
    end
  end

  // Shift the read tags; stage 0 captures a read grant on this bank.
  always_comb begin
    for (int b = 0; b < NUM_SRAMS; b++) begin
      pipe_vld_d[b][0] = bank_any[b] && !req_we[bank_win[b]];
      pipe_cid_d[b][0] = bank_win[b];
      for (int s = 1; s < LAT; s++) begin
        pipe_vld_d[b][s] = pipe_vld_q[b][s-1];
        pipe_cid_d[b][s] = pipe_cid_q[b][s-1];
      end
    end
  end

  // Route matured reads to their clients; rdata holds otherwise.
  always_comb begin
    rsp_valid   = '0;
    rsp_rdata_d = rsp_rdata_q;
    for (int b = 0; b < NUM_SRAMS; b++) begin
      if (arst && pipe_vld_q[b][LAT-1]) begin
        rsp_valid[pipe_cid_q[b][LAT-1]]                       = 1'b1;
        rsp_rdata_d[int'(pipe_cid_q[b][LAT-1])*DW +: DW]      = sram_rdata[b*DW +: DW];
      end
    end
  end

  assign rsp_rdata = rsp_rdata_d;

  // Tag pipeline and held read data; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (!arst) begin
      for (int b = 0; b < NUM_SRAMS; b++) begin
        for (int s = 0; s < LAT; s++) begin
          pipe_vld_q[b][s] <= 1'b0;
          pipe_cid_q[b][s] <= '0;
        end
      end
      rsp_rdata_q <= '0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_cid_q  <= pipe_cid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter with a behavioural SRAM model, a
// response scoreboard and per-cycle grant/drive checks.
module tb_sram_bank_arbiter;
  import npu_mem_pkg::*;

  localparam int NC     = 4;
  localparam int NS     = 4;
  localparam int AW     = 12;
  localparam int DW     = 64;
  localparam int BW     = 2;
  localparam int RD_LAT = 3;
  localparam int EW     = 32 + 2 + DW;

  // Clock / reset
  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NC-1:0]    req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [NC*BW-1:0] req_bank;
  logic [NC*AW-1:0] req_addr;
  logic [NC*DW-1:0] req_wdata, rsp_rdata;
  logic [NS-1:0]    sram_en, sram_we, bank_busy;
  logic [NS*AW-1:0] sram_addr;
  logic [NS*DW-1:0] sram_wdata, sram_rdata;

  sram_bank_arbiter #(
    .NUM_CLIENTS     (NC),
    .NUM_SRAMS       (NS),
    .MAX_ADDR_WIDTH  (AW),
    .MAX_DATA_WIDTH  (DW),
    .SRAM_RD_LATENCY (RD_LAT),
    .PRIO_EN         (1'b1),
    .PRIO_CLIENT     (CLI_AXI4)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_lock   (req_lock),
    .req_bank   (req_bank),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .bank_busy  (bank_busy)
  );

  // Behavioural SRAM banks with RD_LAT-cycle read latency
  logic [DW-1:0] mem     [NS][4096];
  logic [DW-1:0] rd_pipe [NS][RD_LAT];

  function automatic logic [DW-1:0] pat(input int b, input int a);
    return 64'hC0DE_0000_0000_0000 | (64'(b) << 32) | 64'(a);
  endfunction

  initial begin
    for (int b = 0; b < NS; b++)
      for (int a = 0; a < 4096; a++) mem[b][a] = pat(b, a);
  end

  always @(posedge clk) begin
    for (int b = 0; b < NS; b++) begin
      if (sram_en[b] && sram_we[b]) mem[b][sram_addr[b*AW +: AW]] <= sram_wdata[b*DW +: DW];
      if (sram_en[b] && !sram_we[b]) rd_pipe[b][0] <= mem[b][sram_addr[b*AW +: AW]];
      for (int s = 1; s < RD_LAT; s++) rd_pipe[b][s] <= rd_pipe[b][s-1];
    end
  end

  always_comb begin
    sram_rdata = '0;
    for (int b = 0; b < NS; b++) sram_rdata[b*DW +: DW] = rd_pipe[b][RD_LAT-1];
  end

  // Scoreboard state
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] ref_wr [int];

  task automatic chk(input logic [63:0] act, input logic [63:0] exp, input string name);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input int b, input int a);
    if (ref_wr.exists(b*4096 + a)) return ref_wr[b*4096 + a];
    return pat(b, a);
  endfunction

  // Driver tasks
  task automatic clr();
    req_valid = '0; req_we = '0; req_lock = '0;
    req_bank = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic put(input int c, input int b, input logic we, input logic lk,
                     input int a, input logic [DW-1:0] wd);
    req_valid[c]            = 1'b1;
    req_we[c]               = we;
    req_lock[c]             = lk;
    req_bank[c*BW +: BW]    = BW'(b);
    req_addr[c*AW +: AW]    = AW'(a);
    req_wdata[c*DW +: DW]   = wd;
  endtask

  task automatic drop(input int c);
    req_valid[c] = 1'b0;
    req_lock[c]  = 1'b0;
  endtask

  // One cycle: check grants, bank drive and busy mid-cycle, queue the
  // expected read responses of the granted reads, then advance.
  task automatic step(input logic [NC-1:0] exp_rdy, input logic [NS-1:0] exp_busy,
                      input bit push_rsp, input string name);
    logic [NS-1:0] exp_en;
    int b, a;
    @(negedge clk);
    chk(req_ready, exp_rdy, {name, " ready"});
    chk(bank_busy, exp_busy, {name, " busy"});
    exp_en = '0;
    for (int c = 0; c < NC; c++) begin
      if (exp_rdy[c]) begin
        b = int'(req_bank[c*BW +: BW]);
        a = int'(req_addr[c*AW +: AW]);
        exp_en[b] = 1'b1;
        chk(sram_we[b], req_we[c], {name, " we"});
        chk(sram_addr[b*AW +: AW], a, {name, " addr"});
        if (req_we[c]) begin
          chk(sram_wdata[b*DW +: DW], req_wdata[c*DW +: DW], {name, " wdata"});
          ref_wr[b*4096 + a] = req_wdata[c*DW +: DW];
        end else if (push_rsp) begin
          exp_q.push_back({32'(cyc + RD_LAT), 2'(c), ref_rd(b, a)});
        end
      end
    end
    chk(sram_en, exp_en, {name, " en"});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic [NS-1:0] busy);
    for (int i = 0; i < n; i++) step('0, busy, 1'b1, "idle");
  endtask

  // Monitor: pop and compare on each rsp_valid pulse, flag missed responses,
  // and check rsp_rdata holds between pulses.
  logic [DW-1:0] last_rd [NC];
  bit rst_pend = 1'b1;
  initial begin
    logic [EW-1:0] e;
    for (int c = 0; c < NC; c++) last_rd[c] = '0;
    forever begin
      @(negedge clk);
      if (!arst) rst_pend = 1'b1;
      else if (rst_pend) begin
        for (int c = 0; c < NC; c++) last_rd[c] = '0;
        rst_pend = 1'b0;
      end
      for (int c = 0; c < NC; c++) begin
        if (rsp_valid[c]) begin
          if (exp_q.size() == 0) begin
            chk(rsp_valid[c], 1'b0, "rsp_unexpected");
          end else begin
            e = exp_q.pop_front();
            chk(c, e[DW+1 -: 2], "rsp_client");
            chk(cyc, e[EW-1 -: 32], "rsp_cycle");
            chk(rsp_rdata[c*DW +: DW], e[DW-1:0], "rsp_data");
          end
          last_rd[c] = rsp_rdata[c*DW +: DW];
        end else if (arst && !rst_pend) begin
          chk(rsp_rdata[c*DW +: DW], last_rd[c], "rsp_hold");
        end
      end
      while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc) begin
        e = exp_q.pop_front();
        chk(1'b0, 1'b1, "rsp_missing");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    clr();
    arst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset: a held read is not granted and produces nothing until release
    put(CLI_GEMM, 1, 1'b0, 1'b0, 'h010, '0);
    step(4'b0000, 4'b0000, 1'b1, "rst_hold");
    step(4'b0000, 4'b0000, 1'b1, "rst_hold");
    step(4'b0000, 4'b0000, 1'b1, "rst_hold");
    arst = 1'b1;
    step(4'b0010, 4'b0000, 1'b1, "rst_first");
    clr();
    idle(RD_LAT + 2, 4'b0000);

    // Single client write then read back
    put(CLI_AXI4, 0, 1'b1, 1'b0, 5, 64'hA5A5);
    step(4'b0001, 4'b0000, 1'b1, "axi_wr");
    put(CLI_AXI4, 0, 1'b0, 1'b0, 5, '0);
    step(4'b0001, 4'b0000, 1'b1, "axi_rd");
    clr();
    idle(RD_LAT + 1, 4'b0000);

    // Round-robin among GEMM, ELEM, QUANT on bank 2, one grant per cycle
    put(CLI_GEMM,  2, 1'b0, 1'b0, 'h100, '0);
    put(CLI_ELEM,  2, 1'b0, 1'b0, 'h200, '0);
    put(CLI_QUANT, 2, 1'b0, 1'b0, 'h300, '0);
    step(4'b0010, 4'b0000, 1'b1, "rr1");
    step(4'b0100, 4'b0000, 1'b1, "rr2");
    step(4'b1000, 4'b0000, 1'b1, "rr3");
    step(4'b0010, 4'b0000, 1'b1, "rr4");
    step(4'b0100, 4'b0000, 1'b1, "rr5");
    step(4'b1000, 4'b0000, 1'b1, "rr6");
    clr();
    idle(RD_LAT + 1, 4'b0000);

    // Priority: AXI4 beats GEMM on bank 0 even though rr points at GEMM
    put(CLI_AXI4, 0, 1'b0, 1'b0, 'h040, '0);
    put(CLI_GEMM, 0, 1'b0, 1'b0, 'h041, '0);
    step(4'b0001, 4'b0000, 1'b1, "prio_axi");
    drop(CLI_AXI4);
    step(4'b0010, 4'b0000, 1'b1, "prio_gemm");
    clr();
    idle(RD_LAT + 1, 4'b0000);

    // Lock: ELEM locks bank 3, QUANT and even AXI4 are blocked until release
    put(CLI_ELEM, 3, 1'b0, 1'b1, 'h333, '0);
    step(4'b0100, 4'b0000, 1'b1, "lock_set");
    drop(CLI_ELEM);
    put(CLI_QUANT, 3, 1'b0, 1'b0, 'h3A0, '0);
    step(4'b0000, 4'b1000, 1'b1, "lock_blk");
    step(4'b0000, 4'b1000, 1'b1, "lock_blk");
    put(CLI_AXI4, 3, 1'b0, 1'b0, 'h3B0, '0);
    step(4'b0000, 4'b1000, 1'b1, "lock_blk_prio");
    step(4'b0000, 4'b1000, 1'b1, "lock_blk_prio");
    drop(CLI_AXI4);
    put(CLI_ELEM, 3, 1'b0, 1'b0, 'h334, '0);
    step(4'b0100, 4'b1000, 1'b1, "lock_rel");
    drop(CLI_ELEM);
    step(4'b1000, 4'b0000, 1'b1, "lock_quant");
    clr();
    idle(RD_LAT + 1, 4'b0000);

    // Parallel banks: both reads return together RD_LAT cycles later
    put(CLI_GEMM, 0, 1'b0, 1'b0, 'h077, '0);
    put(CLI_ELEM, 1, 1'b0, 1'b0, 'h0AB, '0);
    step(4'b0110, 4'b0000, 1'b1, "par");
    clr();
    idle(RD_LAT + 1, 4'b0000);

    // Same reads, then a reset pulse one cycle later drops them
    put(CLI_GEMM, 0, 1'b0, 1'b0, 'h078, '0);
    put(CLI_ELEM, 1, 1'b0, 1'b0, 'h0AC, '0);
    step(4'b0110, 4'b0000, 1'b0, "par_drop");
    clr();
    arst = 1'b0;
    step(4'b0000, 4'b0000, 1'b0, "drop_rst");
    arst = 1'b1;
    idle(RD_LAT + 3, 4'b0000);

    chk(exp_q.size(), 0, "queue_empty");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_bank_arbiter.md
Name: sram_bank_arbiter

Overview:
- Parametrised multi-client, multi-bank SRAM access arbiter.
- Replaces the fixed per-bank combinational muxing of en/we/addr/data with a per-bank arbiter. Each bank has its own round-robin pointer, an optional strict-priority client and an optional bank lock.
- Uses a valid/ready request handshake and a fixed-latency read-response return path.
- Sits between the AXI4 loader, GEMM, ELEM and QUANT engines and the NUM_SRAMS single-port SRAM macros.

Parameters:
- NUM_CLIENTS, 4, number of requesters (0=AXI4, 1=GEMM, 2=ELEM, 3=QUANT).
- NUM_SRAMS, 4, number of SRAM banks.
- MAX_ADDR_WIDTH, 12, word-address width per bank.
- MAX_DATA_WIDTH, 64, data width per bank.
- SRAM_RD_LATENCY, 1, SRAM read latency in cycles (1..4).
- PRIO_EN, 1, enables strict priority for PRIO_CLIENT.
- PRIO_CLIENT, 0, client index that wins over round-robin when PRIO_EN=1.

Ports:
- clk  in  1  clock.
- arst  in  1  reset; synchronous, active-low.
- req_valid  in  NUM_CLIENTS  per-client request valid.
- req_ready  out  NUM_CLIENTS  per-client grant, combinational from the current-cycle requests.
- req_we  in  NUM_CLIENTS  1=write, 0=read.
- req_lock  in  NUM_CLIENTS  hold ownership of the target bank after this grant.
- req_bank  in  NUM_CLIENTS*BANK_W  target bank index (BANK_W=clog2(NUM_SRAMS)).
- req_addr  in  NUM_CLIENTS*MAX_ADDR_WIDTH  word address.
- req_wdata  in  NUM_CLIENTS*MAX_DATA_WIDTH  write data.
- rsp_valid  out  NUM_CLIENTS  read data valid, one cycle.
- rsp_rdata  out  NUM_CLIENTS*MAX_DATA_WIDTH  read data.
- sram_en  out  NUM_SRAMS  bank enable.
- sram_we  out  NUM_SRAMS  bank write enable.
- sram_addr  out  NUM_SRAMS*MAX_ADDR_WIDTH  bank address.
- sram_wdata  out  NUM_SRAMS*MAX_DATA_WIDTH  bank write data.
- sram_rdata  in  NUM_SRAMS*MAX_DATA_WIDTH  bank read data.
- bank_busy  out  NUM_SRAMS  bank locked, for debug/perf counters.

Behaviour:
- Reset (arst=0 at a clk edge):
  - All rr_ptr=0, all locks cleared, read-tag pipeline flushed.
  - rsp_valid=0, rsp_rdata=0, bank_busy=0.
  - sram_en/sram_we=0 and req_ready=0 for the reset cycle.
  - In-flight reads are dropped; no rsp_valid is produced for them.
- Arbitration (combinational, per bank b):
  - Candidates are clients with req_valid=1 and req_bank=b.
  - If bank b is locked, only the lock owner is eligible.
  - Otherwise, if PRIO_EN and PRIO_CLIENT is a candidate, PRIO_CLIENT wins.
  - Otherwise the round-robin winner is the first candidate at or after rr_ptr[b], modulo NUM_CLIENTS.
  - At most one grant per bank per cycle. A client presents one request per cycle, so it receives at most one grant.
  - req_ready[c]=1 only for the winner. A transfer occurs on req_valid&req_ready.
  - Losing clients hold their request stable; ready may toggle freely.
- SRAM drive:
  - On a grant, sram_en[b]=1, sram_we[b]=req_we, and sram_addr/sram_wdata come from the winner, all in the same cycle.
  - Idle banks drive en=0, we=0, addr=0, wdata=0.
- Round-robin pointer update:
  - At the clk edge after a grant, rr_ptr[b]=winner+1, wrapping to 0.
  - Priority grants and locked grants also advance rr_ptr.
- Lock handling:
  - A grant with req_lock=1 sets lock[b] and owner[b]=winner at the next edge.
  - A grant with req_lock=0 from the owner releases lock[b].
  - If the owner drops req_valid for its locked bank, the lock stays held.
  - A lock owned by the priority client still blocks other clients.
  - bank_busy[b] = lock[b].
- Read return:
  - Each bank has a SRAM_RD_LATENCY-deep pipeline of {valid, client_id}, loaded on a read grant.
  - At the pipeline output, rsp_valid[client_id] pulses and rsp_rdata[client_id] = sram_rdata[b] in the same cycle.
  - Read data is returned exactly SRAM_RD_LATENCY cycles after the grant edge.
  - Responses to the same client from different banks cannot collide, because that client had at most one grant per cycle.
  - rsp_rdata holds its last value when rsp_valid=0.
- Writes produce no response.
- Back-to-back grants to the same bank are allowed every cycle (full throughput).
- Out-of-range req_bank (>= NUM_SRAMS) is never granted.

Decomposition:
- Shared package npu_mem_pkg holds:
  - Client index constants (CLI_AXI4, CLI_GEMM, CLI_ELEM, CLI_QUANT).
  - BANK_W/CLI_W derivations.
  - Bank index constants (GEMM0_SRAM_IDX, GEMM1_SRAM_IDX, ELEM0_SRAM_IDX).
- Sub-module rr_bank_sel: one instance per bank. It contains the candidate mask, the priority/lock override, the rr_ptr register and the lock/owner registers, and outputs a one-hot grant.

Test Plan:
- Reset check: hold arst=0 while GEMM reads bank 1 at addr 0x010 -> no rsp_valid; after release, the first grant returns SRAM data at 0x010 exactly 1 cycle later.
- Single client: AXI4 writes 0xA5A5 to bank 0 addr 5, then reads bank 0 addr 5 -> read grant the next cycle; rsp_valid[0] with 0xA5A5 SRAM_RD_LATENCY cycles after the grant.
- Round-robin fairness: PRIO_EN=0, clients 1, 2 and 3 all request bank 2 continuously -> grant order 1,2,3,1,2,3; each client gets 1/3 of cycles.
- Priority: PRIO_EN=1, AXI4 and GEMM request bank 0 together -> AXI4 granted; GEMM granted in the next cycle after AXI4 drops valid.
- Lock: ELEM gets a bank-3 grant with req_lock=1; QUANT requests bank 3 -> QUANT blocked for 4 cycles while ELEM is idle; granted in the cycle after ELEM's grant with req_lock=0.
- Parallel banks and latency: SRAM_RD_LATENCY=3, GEMM reads bank 0 and ELEM reads bank 1 in the same cycle -> both granted; both rsp_valid pulse 3 cycles later with the correct per-bank data. An arst pulse at cycle +1 -> no responses.
